// File: rtl/mem_result_pager_if.sv
// Read port between the result pager (master) and data memory (slave).
// rd_addr is held stable for as long as rd_req is high.
interface mem_result_pager_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/mem_result_pager.sv
// Post-execution result viewer: walks a window of data memory and presents the
// low nibbles of each fetched word to the 7-segment scanner.
module mem_result_pager #(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_DIGITS    = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(32'h0000_0004),
  parameter int                STRIDE        = 4,
  parameter int                NUM_WORDS     = 16,
  parameter int                DWELL_TICKS   = 1000,
  parameter int                TIMEOUT_TICKS = 8,
  localparam int               IDX_W         = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                    clk_1k,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    auto_mode,
  input  logic                    step,
  input  logic                    wrap_en,
  mem_result_pager_if.master      rd,
  output logic [4*NUM_DIGITS-1:0] disp_data,
  output logic                    disp_valid,
  output logic [IDX_W-1:0]        cur_index,
  output logic                    err,
  output logic                    done
);

  localparam int DISP_W = 4*NUM_DIGITS;
  localparam int DW_W   = (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS-1) : 1;
  localparam int TO_W   = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

  // The SHOW phase lasts DWELL_TICKS-1 cycles; the following fetch cycle
  // completes the dwell, so a zero-wait word is visible exactly DWELL_TICKS.
  localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL_TICKS-2);
  localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_TICKS-1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_WORDS-1);
  localparam logic [ADDR_W-1:0] STRIDE_A   = ADDR_W'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CANCEL,
    S_SHOW,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DISP_W-1:0]   disp_q, disp_d;
  logic                dvld_q, dvld_d;
  logic                err_q, err_d;
  logic [DW_W-1:0]     dwell_q, dwell_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                advance;

  logic [DATA_W-1:0]   unused_rd_data;
  assign unused_rd_data = rd.rd_data;

  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      disp_q  <= '0;
      dvld_q  <= 1'b0;
      err_q   <= 1'b0;
      dwell_q <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      disp_q  <= disp_d;
      dvld_q  <= dvld_d;
      err_q   <= err_d;
      dwell_q <= dwell_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    disp_d  = disp_q;
    dvld_d  = dvld_q;
    err_d   = err_q;
    dwell_d = dwell_q;
    to_d    = to_q;
    advance = 1'b0;

    if (start) begin
      // Restarting over a live request drops rd_req for one cycle first.
      idx_d   = '0;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
      dvld_d  = 1'b0;
      dwell_d = '0;
      to_d    = '0;
      state_d = (state_q == S_FETCH) ? S_CANCEL : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_CANCEL: state_d = S_FETCH;
        S_FETCH: begin
          if (rd.rd_valid) begin
            disp_d  = rd.rd_data[DISP_W-1:0];
            dvld_d  = 1'b1;
            dwell_d = '0;
            to_d    = '0;
            state_d = S_SHOW;
          end else if (to_q == TO_LAST) begin
            disp_d  = {NUM_DIGITS{4'hE}};
            dvld_d  = 1'b1;
            err_d   = 1'b1;
            dwell_d = '0;
            to_d    = '0;
            state_d = S_SHOW;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (step || (auto_mode && (dwell_q == DWELL_LAST))) begin
            advance = 1'b1;
          end else if (auto_mode) begin
            dwell_d = dwell_q + 1'b1;
          end else begin
            dwell_d = '0;
          end
          if (advance) begin
            dwell_d = '0;
            if (idx_q != IDX_LAST) begin
              idx_d   = idx_q + 1'b1;
              addr_d  = addr_q + STRIDE_A;
              state_d = S_FETCH;
            end else if (wrap_en) begin
              idx_d   = '0;
              addr_d  = BASE_ADDR;
              state_d = S_FETCH;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rd.rd_req  = (state_q == S_FETCH);
  assign rd.rd_addr = addr_q;
  assign disp_data  = disp_q;
  assign disp_valid = dvld_q;
  assign cur_index  = idx_q;
  assign err        = err_q;
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_mem_result_pager.sv
// Bench for mem_result_pager: directed steps plus randomized auto-mode runs
// checked against an arithmetic timing model of the paging sequence.
module tb_mem_result_pager;
  localparam int N  = 6;
  localparam int D  = 4;
  localparam int TO = 8;

  logic        clk_1k = 1'b0;
  logic        reset, start, auto_mode, step, wrap_en;
  logic [15:0] disp_data;
  logic        disp_valid, err, done;
  logic [2:0]  cur_index;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:15];
  int          wait_n = 0;
  int          wcnt = 0;
  logic        never_v = 1'b0;
  logic        force_v = 1'b0;

  mem_result_pager_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_result_pager #(
    .ADDR_W(32), .DATA_W(32), .NUM_DIGITS(4), .BASE_ADDR(32'h4), .STRIDE(4),
    .NUM_WORDS(N), .DWELL_TICKS(D), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk_1k(clk_1k), .reset(reset), .start(start), .auto_mode(auto_mode),
    .step(step), .wrap_en(wrap_en), .rd(bus), .disp_data(disp_data),
    .disp_valid(disp_valid), .cur_index(cur_index), .err(err), .done(done)
  );

  always #5 clk_1k = ~clk_1k;

  // Memory slave: answers after wait_n cycles of a continuous request.
  always @(posedge clk_1k) begin
    if (bus.rd_req) wcnt <= wcnt + 1;
    else            wcnt <= 0;
  end

  always_comb begin
    bus.rd_valid = force_v | (bus.rd_req && !never_v && (wcnt >= wait_n));
    bus.rd_data  = force_v ? 32'hDEAD_BEEF : mem[bus.rd_addr[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_1k);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  function automatic logic [15:0] word(input int i);
    logic [31:0] w;
    w = mem[i+1];
    return w[15:0];
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_req"},  32'(bus.rd_req), 32'd0);
    chk({tag, "_rd_addr"}, bus.rd_addr, 32'h4);
    chk({tag, "_disp"},    32'(disp_data), 32'd0);
    chk({tag, "_dvalid"},  32'(disp_valid), 32'd0);
    chk({tag, "_index"},   32'(cur_index), 32'd0);
    chk({tag, "_err"},     32'(err), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
  endtask

  // Auto-mode run: each word takes P = D + w cycles (w+1 fetch cycles, then
  // D-1 show cycles); t counts cycles after start was taken.
  task automatic run_auto(input int w, input bit wr);
    int P, len, e_idx, e_word;
    bit e_done, e_req, e_vld;
    P   = D + w;
    len = N*P + 10;
    do_reset();
    fill_mem();
    wait_n = w; never_v = 1'b0; auto_mode = 1'b1; wrap_en = wr; step = 1'b0;
    pulse_start();
    for (int t = 1; t <= len; t++) begin
      e_word = 0;
      if (!wr && (t >= 1 + N*P)) begin
        e_done = 1'b1; e_idx = N-1; e_req = 1'b0; e_vld = 1'b1; e_word = N-1;
      end else begin
        e_done = 1'b0;
        e_idx  = ((t-1)/P) % N;
        e_req  = (((t-1) % P) <= w);
        e_vld  = (t >= 2 + w);
        if (e_vld) e_word = ((t-2-w)/P) % N;
      end
      chk("auto_done",   32'(done), 32'(e_done));
      chk("auto_index",  32'(cur_index), 32'(e_idx));
      chk("auto_rd_req", 32'(bus.rd_req), 32'(e_req));
      chk("auto_rd_addr", bus.rd_addr, 32'(4 + 4*e_idx));
      chk("auto_dvalid", 32'(disp_valid), 32'(e_vld));
      if (e_vld) chk("auto_disp", 32'(disp_data), 32'(word(e_word)));
      cyc();
    end
  endtask

  initial begin
    int n;
    logic [15:0] w0;
    start = 1'b0; auto_mode = 1'b1; step = 1'b0; wrap_en = 1'b0; reset = 1'b0;
    fill_mem();
    #1 reset = 1'b1;
    #2;
    chk_reset_vals("reset");
    cyc();
    reset = 1'b0;

    // Zero-wait auto paging, stop at end and wrap, then randomized runs
    run_auto(0, 1'b0);
    run_auto(0, 1'b1);
    for (int r = 0; r < 4; r++) run_auto(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    // Manual mode with a two-wait-state memory
    do_reset();
    fill_mem();
    auto_mode = 1'b0; wrap_en = 1'b0; wait_n = 2;
    pulse_start();
    n = 0;
    for (int i = 0; i < 20 && !disp_valid; i++) begin
      if (bus.rd_req) n++;
      cyc();
    end
    chk("man_bound", 32'(disp_valid), 32'd1);
    chk("man_req_cycles", 32'(n), 32'd3);
    chk("man_disp0", 32'(disp_data), 32'(word(0)));
    for (int i = 0; i < 8; i++) cyc();
    chk("man_hold_disp", 32'(disp_data), 32'(word(0)));
    chk("man_hold_index", 32'(cur_index), 32'd0);
    pulse_step();
    chk("man_step_req", 32'(bus.rd_req), 32'd1);
    chk("man_step_addr", bus.rd_addr, 32'h8);
    chk("man_keep_old", 32'(disp_data), 32'(word(0)));
    pulse_step();
    for (int i = 0; i < 5; i++) cyc();
    chk("man_fetch_step_index", 32'(cur_index), 32'd1);
    chk("man_disp1", 32'(disp_data), 32'(word(1)));
    pulse_step();
    for (int i = 0; i < 5; i++) cyc();
    chk("man_index2", 32'(cur_index), 32'd2);
    chk("man_disp2", 32'(disp_data), 32'(word(2)));

    // Read timeout
    do_reset();
    never_v = 1'b1; wait_n = 0;
    pulse_start();
    n = 0;
    for (int i = 0; i < 30 && !disp_valid; i++) begin
      if (bus.rd_req) n++;
      cyc();
    end
    chk("to_bound", 32'(disp_valid), 32'd1);
    chk("to_req_cycles", 32'(n), 32'(TO));
    chk("to_disp", 32'(disp_data), 32'hEEEE);
    chk("to_err", 32'(err), 32'd1);
    never_v = 1'b0;
    pulse_step();
    cyc();
    chk("to_next_disp", 32'(disp_data), 32'(word(1)));
    chk("to_next_index", 32'(cur_index), 32'd1);
    chk("to_err_sticky", 32'(err), 32'd1);
    pulse_start();
    chk("to_err_clear", 32'(err), 32'd0);
    chk("to_dvalid_clear", 32'(disp_valid), 32'd0);

    // Restart in the middle of fetching the last word
    do_reset();
    fill_mem();
    wait_n = 0;
    pulse_start();
    cyc();
    for (int j = 1; j <= 4; j++) begin
      pulse_step();
      cyc();
    end
    chk("cx_disp4", 32'(disp_data), 32'(word(4)));
    wait_n = 10;
    pulse_step();
    chk("cx_req5", 32'(bus.rd_req), 32'd1);
    chk("cx_addr5", bus.rd_addr, 32'h18);
    cyc();
    pulse_start();
    chk("cx_gap_req", 32'(bus.rd_req), 32'd0);
    chk("cx_gap_index", 32'(cur_index), 32'd0);
    chk("cx_gap_dvalid", 32'(disp_valid), 32'd0);
    force_v = 1'b1; wait_n = 0;
    cyc();
    force_v = 1'b0;
    chk("cx_refetch_req", 32'(bus.rd_req), 32'd1);
    chk("cx_refetch_addr", bus.rd_addr, 32'h4);
    chk("cx_stale_ignored", 32'(disp_valid), 32'd0);
    cyc();
    chk("cx_disp0", 32'(disp_data), 32'(word(0)));

    // Asynchronous reset while showing a word
    do_reset();
    fill_mem();
    auto_mode = 1'b1; wait_n = 0;
    pulse_start();
    cyc();
    cyc();
    chk("ar_before", 32'(disp_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    cyc();
    reset = 1'b0;
    cyc();
    pulse_start();
    chk("ar_resume_req", 32'(bus.rd_req), 32'd1);
    chk("ar_resume_addr", bus.rd_addr, 32'h4);
    cyc();
    w0 = word(0);
    chk("ar_resume_disp", 32'(disp_data), 32'(w0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
